// File: rtl/diff_cascade.sv
// diff_cascade: runtime-selectable k-th order lagged difference cascade; DIFF_CASCADE_SAT_EN enables output saturation
module diff_cascade #(
  parameter int DATA_WIDTH = 16,
  parameter int LAG = 1,
  parameter int ORDER_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  logic [3:0]                   order,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         ovf
);
  localparam int W = DATA_WIDTH + ORDER_MAX;
  logic signed [W-1:0] res [ORDER_MAX+1];
  logic vld [ORDER_MAX+1];
  logic [3:0] keff;
  logic signed [W-1:0] full;
  assign res[0] = W'(data);
  assign vld[0] = in_valid;
  for (genvar k = 0; k < ORDER_MAX; k++) begin : g_stage
    logic signed [W-1:0] r;
    logic v;
    logic signed [W-1:0] h [LAG];
    // one difference stage: history advances only on valid samples
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r <= '0;
        v <= 1'b0;
        for (int i = 0; i < LAG; i++) h[i] <= '0;
      end else begin
        v <= vld[k];
        if (vld[k]) begin
          r <= res[k] - h[LAG-1];
          h[0] <= res[k];
          for (int i = 1; i < LAG; i++) h[i] <= h[i-1];
        end
      end
    assign res[k+1] = r;
    assign vld[k+1] = v;
  end
  // clamp requested order into 1..ORDER_MAX and select that stage
  always_comb begin
    keff = order == 4'd0 ? 4'd1 : order > 4'(ORDER_MAX) ? 4'(ORDER_MAX) : order;
    full = '0;
    out_valid = 1'b0;
    for (int i = 1; i <= ORDER_MAX; i++)
      if (keff == 4'(i)) begin
        full = res[i];
        out_valid = vld[i];
      end
  end
`ifdef DIFF_CASCADE_SAT_EN
  localparam logic signed [W-1:0] SMAX = {{(W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {{(W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  // clip full-precision result to the output range
  always_comb begin
    ovf = full > SMAX || full < SMIN;
    out = ovf ? (full[W-1] ? SMIN[DATA_WIDTH-1:0] : SMAX[DATA_WIDTH-1:0]) : full[DATA_WIDTH-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^full[W-1:DATA_WIDTH];
  assign out = full[DATA_WIDTH-1:0];
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_diff_cascade.sv
// tb_diff_cascade: randomized and directed checks of diff_cascade against a binomial-sum reference
module tb_diff_cascade;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_valid2 = 0;
  logic signed [15:0] data = 0, data2 = 0;
  logic [3:0] order = 1;
  logic out_valid, ovf, out_valid2, ovf2;
  logic signed [15:0] out, out2;
  int errors = 0, checks = 0;
  longint xs[$];
  int acc[$];

  diff_cascade #(.DATA_WIDTH(16), .LAG(1), .ORDER_MAX(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .order(order),
    .out_valid(out_valid), .out(out), .ovf(ovf));
  diff_cascade #(.DATA_WIDTH(16), .LAG(2), .ORDER_MAX(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .data(data2), .order(4'd1),
    .out_valid(out_valid2), .out(out2), .ovf(ovf2));

  always #5 clk = ~clk;

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // k-th lagged difference of the n-th accepted sample: sum (-1)^j C(k,j) x[n-1-j*lag]
  function automatic longint diffk(int k, int n, int lag);
    longint s = 0, c = 1;
    if (n == 0) return 0;
    for (int j = 0; j <= k; j++) begin
      if (n - 1 - j * lag >= 0) s += ((j % 2) ? -c : c) * xs[n-1-j*lag];
      c = c * (k - j) / (j + 1);
    end
    return s;
  endfunction

  function automatic longint red_out(longint v);
`ifdef DIFF_CASCADE_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    logic signed [15:0] w;
    w = 16'(v);
    return longint'(w);
`endif
  endfunction

  function automatic longint red_ovf(longint v);
`ifdef DIFF_CASCADE_SAT_EN
    return (v > 32767 || v < -32768) ? 1 : 0;
`else
    return (v == v) ? 0 : 1;
`endif
  endfunction

  // drive one cycle, then check against the model: the selected stage reflects samples up to k-1 steps ago
  task automatic step(bit v, logic signed [15:0] d, logic [3:0] o);
    int k, t, idx, n;
    bit ev;
    longint full;
    in_valid = v; data = d; order = o;
    @(posedge clk);
    if (v) xs.push_back(longint'(d));
    acc.push_back(xs.size());
    #1;
    k = o == 0 ? 1 : o > 3 ? 3 : int'(o);
    t = acc.size() - 1;
    idx = t - k + 1;
    n = idx >= 0 ? acc[idx] : 0;
    ev = idx >= 0 && acc[idx] != (idx > 0 ? acc[idx-1] : 0);
    full = diffk(k, n, 1);
    chk("out_valid", longint'(out_valid), longint'(ev));
    chk("out", longint'(out), red_out(full));
    chk("ovf", longint'(ovf), red_ovf(full));
  endtask

  task automatic do_reset();
    in_valid = 1; data = 99;
    rst = 1;
    #1;
    chk("async_rst_out", longint'(out), 0);
    chk("async_rst_valid", longint'(out_valid), 0);
    chk("async_rst_ovf", longint'(ovf), 0);
    xs.delete(); acc.delete();
    @(posedge clk);
    #1;
    rst = 0; in_valid = 0;
    chk("rst_drop_valid", longint'(out_valid), 0);
  endtask

  initial begin
    longint exp1[6] = '{5, 5, -7, -7, 12, 0};
    longint exp2[6] = '{5, 0, -12, 0, 19, -12};
    longint stim[6] = '{5, 10, 3, -4, 8, 8};
    longint l2in[4] = '{1, 2, 4, 8};
    longint l2ex[4] = '{1, 2, 3, 6};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", longint'(out), 0);
    chk("reset_valid", longint'(out_valid), 0);
    chk("reset_ovf", longint'(ovf), 0);
    rst = 0;
    // order=1 back-to-back
    for (int i = 0; i < 6; i++) begin
      step(1, 16'(stim[i]), 1);
      chk("ord1_const", longint'(out), exp1[i]);
    end
    step(0, 0, 1);
    // order=2
    do_reset();
    step(1, 16'(stim[0]), 2);
    for (int i = 1; i < 6; i++) begin
      step(1, 16'(stim[i]), 2);
      chk("ord2_const", longint'(out), exp2[i-1]);
    end
    step(0, 0, 2);
    chk("ord2_const", longint'(out), exp2[5]);
    // order=0 and order=9 clamping
    do_reset();
    foreach (stim[i]) step(1, 16'(stim[i]), 0);
    repeat (2) step(0, 0, 0);
    do_reset();
    foreach (stim[i]) step(1, 16'(stim[i]), 9);
    repeat (3) step(0, 0, 9);
    // bubbles: history must not advance on idle cycles
    do_reset();
    step(1, 5, 1);
    chk("bub_first", longint'(out), 5);
    repeat (3) begin
      step(0, 0, 1);
      chk("bub_hold", longint'(out), 5);
    end
    step(1, 10, 1);
    chk("bub_second", longint'(out), 5);
    // overflow
    do_reset();
    step(1, 32767, 1);
    step(1, -32768, 1);
`ifdef DIFF_CASCADE_SAT_EN
    chk("ovf_out", longint'(out), -32768);
    chk("ovf_flag", longint'(ovf), 1);
`else
    chk("ovf_out", longint'(out), 1);
    chk("ovf_flag", longint'(ovf), 0);
`endif
    // reset mid-stream
    do_reset();
    step(1, 15, 1);
    step(1, -10, 1);
    do_reset();
    step(1, 20, 1);
    chk("post_rst", longint'(out), 20);
    // randomized stream with random bubbles and order changes in flight
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] o;
      o = (i % 7 == 0 || i % 11 == 0) ? 4'($urandom_range(0, 15)) : 4'(3 - (i / 50) % 3);
      step($urandom_range(0, 3) != 0, 16'($urandom), o);
    end
    for (int i = 0; i < 100; i++)
      step(1, 16'($urandom_range(0, 3) == 0 ? 32767 : ($urandom_range(0, 1) ? -32768 : 16'($urandom))), 4'($urandom_range(1, 3)));
    // LAG=2 instance
    in_valid = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1; data2 = 16'(l2in[i]);
      @(posedge clk);
      #1;
      chk("lag2_valid", longint'(out_valid2), 1);
      chk("lag2_out", longint'(out2), l2ex[i]);
    end
    in_valid2 = 0;
    @(posedge clk);
    #1;
    chk("lag2_idle", longint'(out_valid2), 0);
    chk("lag2_hold", longint'(out2), 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
